// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the five-stage pipeline control logic.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALT    = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr takes priority over inc.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the IF-ID-EX-MEM-WB pipeline: arbitrates HLT,
// main-memory waits with timeout, taken-branch flushes and load-use stalls.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic             mem_access,
  input  logic             mem_ack,
  input  logic             halt_wb,
  input  logic             restart,
  output logic             en_pc,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             en_exmem,
  output logic             en_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             flush_memwb,
  output logic             mem_req,
  output logic             halted,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cycles
);

  ctrl_state_t     state, next_state;
  logic [TO_W-1:0] to_count;
  logic            mem_wait;
  logic            to_inc;
  logic            to_fire;

  // Once in MEMWAIT the access is outstanding until ack, whatever mem_access does.
  assign mem_wait = (state == MEMWAIT) ? !mem_ack : (mem_access && !mem_ack);

  always_comb begin
    next_state  = state;
    en_pc       = 1'b1;
    en_ifid     = 1'b1;
    en_idex     = 1'b1;
    en_exmem    = 1'b1;
    en_memwb    = 1'b1;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    flush_memwb = 1'b0;
    mem_req     = 1'b0;
    to_inc      = 1'b0;
    to_fire     = 1'b0;
    case (state)
      RUN, MEMWAIT: begin
        mem_req = mem_access;
        if (halt_wb) begin
          // Squash everything younger than the HLT while it retires.
          en_pc       = 1'b0;
          flush_ifid  = 1'b1;
          flush_idex  = 1'b1;
          flush_exmem = 1'b1;
          flush_memwb = 1'b1;
          mem_req     = 1'b0;
          next_state  = HALT;
        end else if (mem_wait) begin
          en_pc       = 1'b0;
          en_ifid     = 1'b0;
          en_idex     = 1'b0;
          en_exmem    = 1'b0;
          flush_memwb = 1'b1;
          to_inc      = 1'b1;
          if (to_count == TO_W'(TIMEOUT - 1)) begin
            to_fire    = 1'b1;
            next_state = HALT;
          end else begin
            next_state = MEMWAIT;
          end
        end else begin
          next_state = RUN;
          if (branch_taken) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
          end else if (load_use) begin
            en_pc      = 1'b0;
            en_ifid    = 1'b0;
            flush_idex = 1'b1;
          end
        end
      end
      HALT: begin
        en_pc    = 1'b0;
        en_ifid  = 1'b0;
        en_idex  = 1'b0;
        en_exmem = 1'b0;
        en_memwb = 1'b0;
        if (restart) next_state = RUN;
      end
      default: next_state = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      halted      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state  <= next_state;
      halted <= (next_state == HALT);
      if ((state == HALT) && restart) begin
        timeout_err <= 1'b0;
      end else if (to_fire) begin
        timeout_err <= 1'b1;
      end
    end
  end

  sat_counter #(.W(TO_W)) u_timeout_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (to_inc),
    .clr   (next_state != MEMWAIT),
    .count (to_count)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   ((state != HALT) && !en_pc),
    .clr   ((state == HALT) && restart),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (TIMEOUT=4): each task drives one scenario and
// checks combinational outputs mid-cycle and registered outputs after the edge.
module tb_pipe_ctrl;

  localparam int CNT_W = 16;

  logic             clk;
  logic             reset;
  logic             load_use, branch_taken, mem_access, mem_ack, halt_wb, restart;
  logic             en_pc, en_ifid, en_idex, en_exmem, en_memwb;
  logic             flush_ifid, flush_idex, flush_exmem, flush_memwb;
  logic             mem_req, halted, timeout_err;
  logic [CNT_W-1:0] stall_cycles;

  logic [4:0] en_v;
  logic [3:0] fl_v;
  assign en_v = {en_pc, en_ifid, en_idex, en_exmem, en_memwb};
  assign fl_v = {flush_ifid, flush_idex, flush_exmem, flush_memwb};

  int n_cmp = 0;
  int n_bad = 0;

  pipe_ctrl #(.TIMEOUT(4), .TO_W(8), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_use     (load_use),
    .branch_taken (branch_taken),
    .mem_access   (mem_access),
    .mem_ack      (mem_ack),
    .halt_wb      (halt_wb),
    .restart      (restart),
    .en_pc        (en_pc),
    .en_ifid      (en_ifid),
    .en_idex      (en_idex),
    .en_exmem     (en_exmem),
    .en_memwb     (en_memwb),
    .flush_ifid   (flush_ifid),
    .flush_idex   (flush_idex),
    .flush_exmem  (flush_exmem),
    .flush_memwb  (flush_memwb),
    .mem_req      (mem_req),
    .halted       (halted),
    .timeout_err  (timeout_err),
    .stall_cycles (stall_cycles)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    load_use = 0; branch_taken = 0; mem_access = 0;
    mem_ack = 0; halt_wb = 0; restart = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #2 reset = 1;
    step();
    n_cmp++; if (en_v !== 5'b11111) begin n_bad++; $display("FAIL rst_en: got %b want 11111", en_v); end
    n_cmp++; if (fl_v !== 4'b0000) begin n_bad++; $display("FAIL rst_flush: got %b want 0000", fl_v); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL rst_halted: got %b want 0", halted); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL rst_terr: got %b want 0", timeout_err); end
    n_cmp++; if (stall_cycles !== 16'd0) begin n_bad++; $display("FAIL rst_stall: got %0d want 0", stall_cycles); end
  endtask

  task automatic test_load_use();
    load_use = 1;
    #1;
    n_cmp++; if (en_v !== 5'b00111) begin n_bad++; $display("FAIL lu_en: got %b want 00111", en_v); end
    n_cmp++; if (fl_v !== 4'b0100) begin n_bad++; $display("FAIL lu_flush: got %b want 0100", fl_v); end
    step();
    load_use = 0;
    #1;
    n_cmp++; if (stall_cycles !== 16'd1) begin n_bad++; $display("FAIL lu_stall: got %0d want 1", stall_cycles); end
    n_cmp++; if (en_v !== 5'b11111) begin n_bad++; $display("FAIL lu_release_en: got %b want 11111", en_v); end
  endtask

  task automatic test_branch();
    branch_taken = 1; load_use = 1;
    #1;
    n_cmp++; if (en_v !== 5'b11111) begin n_bad++; $display("FAIL br_en: got %b want 11111", en_v); end
    n_cmp++; if (fl_v !== 4'b1100) begin n_bad++; $display("FAIL br_flush: got %b want 1100", fl_v); end
    step();
    clear_inputs();
    n_cmp++; if (stall_cycles !== 16'd1) begin n_bad++; $display("FAIL br_stall: got %0d want 1", stall_cycles); end
  endtask

  task automatic test_back_to_back();
    load_use = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (en_v !== 5'b00111) begin n_bad++; $display("FAIL b2b_en[%0d]: got %b want 00111", i, en_v); end
      step();
    end
    clear_inputs();
    n_cmp++; if (stall_cycles !== 16'd3) begin n_bad++; $display("FAIL b2b_stall: got %0d want 3", stall_cycles); end
  endtask

  task automatic test_mem_wait();
    mem_access = 1; mem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (en_v !== 5'b00001) begin n_bad++; $display("FAIL mw_en[%0d]: got %b want 00001", i, en_v); end
      n_cmp++; if (fl_v !== 4'b0001) begin n_bad++; $display("FAIL mw_flush[%0d]: got %b want 0001", i, fl_v); end
      n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL mw_req[%0d]: got %b want 1", i, mem_req); end
      step();
    end
    mem_ack = 1;
    #1;
    n_cmp++; if (en_v !== 5'b11111) begin n_bad++; $display("FAIL mw_ack_en: got %b want 11111", en_v); end
    n_cmp++; if (fl_v !== 4'b0000) begin n_bad++; $display("FAIL mw_ack_flush: got %b want 0000", fl_v); end
    step();
    n_cmp++; if (stall_cycles !== 16'd6) begin n_bad++; $display("FAIL mw_stall: got %0d want 6", stall_cycles); end
    // zero-wait access straight from RUN
    #1;
    n_cmp++; if (en_v !== 5'b11111) begin n_bad++; $display("FAIL zw_en: got %b want 11111", en_v); end
    step();
    clear_inputs();
    n_cmp++; if (stall_cycles !== 16'd6) begin n_bad++; $display("FAIL zw_stall: got %0d want 6", stall_cycles); end
  endtask

  task automatic test_timeout();
    mem_access = 1; mem_ack = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (en_v !== 5'b00001) begin n_bad++; $display("FAIL to_en[%0d]: got %b want 00001", i, en_v); end
      step();
      if (i < 3) begin
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL to_early_halt[%0d]: got %b want 0", i, halted); end
      end
    end
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL to_halted: got %b want 1", halted); end
    n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_terr: got %b want 1", timeout_err); end
    n_cmp++; if (stall_cycles !== 16'd10) begin n_bad++; $display("FAIL to_stall: got %0d want 10", stall_cycles); end
    #1;
    n_cmp++; if (en_v !== 5'b00000) begin n_bad++; $display("FAIL halt_en: got %b want 00000", en_v); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL halt_req: got %b want 0", mem_req); end
    step();
    n_cmp++; if (stall_cycles !== 16'd10) begin n_bad++; $display("FAIL halt_stall_hold: got %0d want 10", stall_cycles); end
    // restart beats a simultaneous halt_wb
    restart = 1; halt_wb = 1;
    #1;
    n_cmp++; if (fl_v !== 4'b0000) begin n_bad++; $display("FAIL halt_flush: got %b want 0000", fl_v); end
    step();
    clear_inputs();
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL rs_halted: got %b want 0", halted); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL rs_terr: got %b want 0", timeout_err); end
    n_cmp++; if (stall_cycles !== 16'd0) begin n_bad++; $display("FAIL rs_stall: got %0d want 0", stall_cycles); end
    #1;
    n_cmp++; if (en_v !== 5'b11111) begin n_bad++; $display("FAIL rs_en: got %b want 11111", en_v); end
  endtask

  task automatic test_halt_in_memwait();
    mem_access = 1; mem_ack = 0;
    step();
    halt_wb = 1;
    #1;
    n_cmp++; if (en_v !== 5'b01111) begin n_bad++; $display("FAIL hm_en: got %b want 01111", en_v); end
    n_cmp++; if (fl_v !== 4'b1111) begin n_bad++; $display("FAIL hm_flush: got %b want 1111", fl_v); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL hm_req: got %b want 0", mem_req); end
    step();
    clear_inputs();
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL hm_halted: got %b want 1", halted); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL hm_terr: got %b want 0", timeout_err); end
    n_cmp++; if (stall_cycles !== 16'd2) begin n_bad++; $display("FAIL hm_stall: got %0d want 2", stall_cycles); end
    #2 reset = 0;
    #1;
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL ar_halted: got %b want 0", halted); end
    n_cmp++; if (stall_cycles !== 16'd0) begin n_bad++; $display("FAIL ar_stall: got %0d want 0", stall_cycles); end
    n_cmp++; if (en_v !== 5'b11111) begin n_bad++; $display("FAIL ar_en: got %b want 11111", en_v); end
    step();
    reset = 1;
    step();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_back_to_back();
    test_mem_wait();
    test_timeout();
    test_halt_in_memwait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush sequencer for the 16-bit five-stage pipeline (IF, ID, EX, MEM, WB).
- Drives the enable and flush inputs of the PC register and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Arbitrates between load-use stalls, taken-branch flushes, multi-cycle main-memory waits with timeout, and HLT halting.
- Keeps a saturating stall-cycle counter for performance measurement.

Parameters:
TIMEOUT, 255, maximum MEMWAIT cycles without mem_ack before an error halt (1..2^TO_W-1)
TO_W, 8, width of the timeout counter
CNT_W, 16, width of the stall_cycles counter

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset
load_use  in  1  ID instruction reads the destination of a load currently in EX
branch_taken  in  1  branch resolved taken in EX (held stable by EX while EX is frozen)
mem_access  in  1  MEM-stage instruction needs main memory
mem_ack  in  1  main memory completes the access this cycle
halt_wb  in  1  HLT instruction is in WB
restart  in  1  one-cycle pulse; leaves HALT
en_pc, en_ifid, en_idex, en_exmem, en_memwb  out  1 each  register enables
flush_ifid, flush_idex, flush_exmem, flush_memwb  out  1 each  synchronous clears (effective only with matching en)
mem_req  out  1  request to main memory
halted  out  1  in HALT state
timeout_err  out  1  sticky; last halt was caused by a memory timeout
stall_cycles  out  CNT_W  saturating count of cycles with en_pc=0 outside HALT

Behaviour:
- States: RUN, MEMWAIT, HALT. Outputs are combinational from state and inputs, except halted, timeout_err and stall_cycles, which are registered.
- Reset (reset=0, asynchronous): state=RUN, timeout counter=0, timeout_err=0, stall_cycles=0. With no hazard inputs active, all en_*=1, all flush_*=0 and mem_req=0.
- Default (RUN, no events): all en_*=1, all flush_*=0.
- Priority, highest first: halt_wb > memory wait > branch_taken > load_use.
- halt_wb in RUN or MEMWAIT:
  - This cycle: en_pc=0, all other en_*=1, flush_ifid/idex/exmem/memwb=1 (squash everything younger than HLT), mem_req=0.
  - Next state HALT.
- HALT:
  - All en_*=0, all flush_*=0, mem_req=0, halted=1; other inputs ignored.
  - restart=1 -> RUN; stall_cycles and timeout_err are cleared on that edge.
  - PC recovery is owned by fetch.
- Memory wait:
  - mem_req = mem_access when state is RUN or MEMWAIT.
  - RUN with mem_access=1 and mem_ack=1: zero-wait access, normal advance.
  - RUN with mem_access=1 and mem_ack=0 -> MEMWAIT. This cycle and every MEMWAIT cycle without ack:
    - en_pc, en_ifid, en_idex, en_exmem = 0.
    - en_memwb=1, flush_memwb=1 (bubble into WB).
  - MEMWAIT with mem_ack=1: normal advance -> RUN. A held branch_taken or load_use is applied in that same cycle under the normal rules.
  - Timeout counter: increments on each MEMWAIT cycle without ack and resets to 0 on leaving MEMWAIT. On the wait cycle where the counter equals TIMEOUT-1 with still no ack: next state HALT, timeout_err=1, stall outputs as above.
- branch_taken (RUN, no higher-priority event): en_*=1, flush_ifid=1, flush_idex=1. A simultaneous load_use is ignored, because its instruction is squashed.
- load_use (RUN, nothing higher): en_pc=0, en_ifid=0, en_idex=1, flush_idex=1 (bubble), en_exmem=en_memwb=1.
- stall_cycles increments each cycle en_pc=0 in RUN/MEMWAIT (including the halt_wb entry cycle) and saturates at 2^CNT_W-1.
- halt_wb and restart in the same HALT cycle: restart wins, because halt_wb is ignored in HALT.

Decomposition:
- Shared pipeline package: ctrl_state_t enum {RUN, MEMWAIT, HALT}.
- Sub-module sat_counter (parameter W; inputs inc and clr; saturating), used for stall_cycles and the timeout counter.

Test Plan:
- Reset released, all inputs 0 -> all en_*=1, flush_*=0, halted=0, stall_cycles=0.
- load_use=1 for 1 cycle -> en_pc=0, en_ifid=0, flush_idex=1; stall_cycles=1 next cycle.
- branch_taken=1 and load_use=1 together -> flush_ifid=flush_idex=1, en_pc=1, stall_cycles unchanged.
- mem_access=1, mem_ack after 3 cycles -> 3 cycles of en_pc=0 with flush_memwb=1, then a normal advance; stall_cycles=3.
- TIMEOUT=4, mem_access=1, no ack -> HALT after 4 wait cycles, timeout_err=1, halted=1; restart -> RUN, timeout_err=0, stall_cycles=0.
- halt_wb=1 during MEMWAIT -> all four flushes asserted, en_pc=0, HALT next cycle; reset=0 asserted mid-HALT -> immediately RUN with all counters 0.
